top_control_core: RTL and testbench
===================================

// Module: top_control_core
// PURPOSE
//  Top of the simple 16-bit accumulator processor: control FSM, PC/AR/IR/AC datapath, ALU,
//  512x16 instruction RAM (IRAM) and 512x16 data RAM (DRAM), all internal.
//  An external loader fills IRAM while the CPU idles; the CPU then runs from address 1.
//  Internal datapath nodes are exported as debug ports.
// PARAMETERS
//  DW      16   datapath / memory word width
//  AW      9    IRAM/DRAM address width (512 words each)
//  PC_INIT 1    first fetch address after reset or run restart
// PORTS
//  clock           in   1   single clock; all state updates on rising edge
//  reset           in   1   synchronous, active-high reset
//  start           in   1   run enable (level)
//  start_2         in   1   load mode (level); overrides start
//  iram_write_ext  in   1   loader write strobe
//  addr_ext        in   9   loader IRAM address
//  Data_in_ins     in   16  loader IRAM write data
//  iram_in         out  16  IRAM read data (instruction word)
//  dram_in         out  16  DRAM write data (= AC)
//  dram_out        out  16  DRAM read data
//  pc_out          out  16  PC, zero-extended
//  ar_out          out  16  AR, zero-extended
//  data_in_pc      out  16  next-PC value presented to PC input
//  alu_in_1/alu_in_2 out 16 ALU operands
//  alu_out         out  16  ALU result
//  control_out     out  20  decoded control word
//  state           out  6   FSM state code
//  read_en         out  2   00 none, 01 DRAM read, 10 IRAM read
//  write_en        out  1   DRAM write strobe
// BEHAVIOUR
//  Reset: PC=1, AR=IR=AC=0, Z=0, state=IDLE; all outputs 0 except pc_out=1 and memory-data
//   outputs; memories not cleared.
//  Load: start_2=1 and state IDLE: each edge with iram_write_ext=1 writes Data_in_ins to IRAM[addr_ext].
//   Repeated writes to the same address are harmless.
//   iram_write_ext is ignored otherwise. start_2=1 forces IDLE and PC=1.
//  Run: IDLE->FETCH when start=1 and start_2=0. start=0 in any state -> IDLE next edge, PC=1.
//  Memories: synchronous read, 1-cycle latency; DRAM write on edge when write_en=1.
//  Instr: op=[15:12], addr=[8:0], imm=[11:0] zero-extended.
//   0 NOP; 1 LDI AC=imm; 2 LOAD AC=M[addr]; 3 STORE M[addr]=AC; 4 ADD AC+=M[addr];
//   5 SUB AC-=M[addr]; 6 JMP PC=addr; 7 JZ if Z PC=addr; 8 INC AC+=1; F HALT;
//   other opcodes act as NOP.
//  States: IDLE=0, FETCH=1, FETCH_W=2, DECODE=3, MEM_RD=4, MEM_W=5, EXEC=6, STORE=7, HALT=63.
//   FETCH: AR<=PC, IRAM read (read_en=10).
//   FETCH_W: IR<=iram_in, PC<=PC+1 (wraps 511->0).
//   DECODE: LOAD/ADD/SUB->MEM_RD (AR<=addr); STORE->STORE; HALT->HALT; else->EXEC.
//   MEM_RD (read_en=01) -> MEM_W -> EXEC.
//   EXEC: write AC/PC per opcode -> FETCH.
//   STORE: AR<=addr, write_en=1 -> FETCH.
//   HALT: hold until reset or start=0.
//  Latency in cycles: NOP/LDI/JMP/JZ/INC/STORE = 4; LOAD/ADD/SUB = 6.
//  ALU: alu_in_1=AC; alu_in_2=DRAM data (ADD/SUB) or 1 (INC); 16-bit modulo result, no carry.
//   Z updated by LDI/LOAD/ADD/SUB/INC (Z = AC_new==0).
//  control_out bits: 0 ld_ar, 1 ld_ir, 2 inc_pc, 3 ld_pc, 4 ld_ac, 5 add, 6 sub, 7 inc,
//   8 ac_imm, 9 ac_mem, 10 dram_wr, 11 dram_rd, 12 iram_rd, 13 halt, 14 z_upd; 19:15 = 0.
//  Combinational from state+IR.
// TESTING
//  Reset held 2 cycles -> state=0, pc_out=1, control_out=0, write_en=0, read_en=0.
//  Load mode: write 16'h1005 at 1, 16'hF000 at 2 (strobe held 4 cycles each) -> IRAM[1], IRAM[2] hold
//   those words; state stays 0.
//  Run: program 1005,300A,400A,300B,F000 at 1..5, start=1 -> DRAM[10]=5, DRAM[11]=10,
//   state=63, pc_out=6.
//  Branch: 1000 (LDI 0), 7005 (JZ 5), 1007, F000, 1009 (at 5), F000 -> AC=9, halt at pc_out=7.
//  Wrap/ALU: LDI FFF, INC x4097 path via ADD of DRAM word 16'hF001 -> AC=0, Z=1.
//  start dropped mid-program -> IDLE next edge, PC=1; start_2 with start=1 -> no fetch.

Source files
------------

// File: rtl/top_control_core.sv
// Simple 16-bit accumulator CPU: control FSM, PC/AR/IR/AC datapath, ALU and private
// instruction/data RAMs. The IRAM is filled by an external loader while the core idles.
module top_control_core #(
  parameter int unsigned DW      = 16,
  parameter int unsigned AW      = 9,
  parameter int unsigned PC_INIT = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          start_2,
  input  logic          iram_write_ext,
  input  logic [AW-1:0] addr_ext,
  input  logic [DW-1:0] Data_in_ins,
  output logic [DW-1:0] iram_in,
  output logic [DW-1:0] dram_in,
  output logic [DW-1:0] dram_out,
  output logic [DW-1:0] pc_out,
  output logic [DW-1:0] ar_out,
  output logic [DW-1:0] data_in_pc,
  output logic [DW-1:0] alu_in_1,
  output logic [DW-1:0] alu_in_2,
  output logic [DW-1:0] alu_out,
  output logic [19:0]   control_out,
  output logic [5:0]    state,
  output logic [1:0]    read_en,
  output logic          write_en
);

  typedef enum logic [5:0] {
    StIdle   = 6'd0,
    StFetch  = 6'd1,
    StFetchW = 6'd2,
    StDecode = 6'd3,
    StMemRd  = 6'd4,
    StMemW   = 6'd5,
    StExec   = 6'd6,
    StStore  = 6'd7,
    StHalt   = 6'd63
  } state_e;

  localparam logic [3:0] OpLdi = 4'h1, OpLoad = 4'h2, OpStore = 4'h3, OpAdd = 4'h4;
  localparam logic [3:0] OpSub = 4'h5, OpJmp = 4'h6, OpJz = 4'h7, OpInc = 4'h8, OpHalt = 4'hF;

  localparam int unsigned CLdAr = 0, CLdIr = 1, CIncPc = 2, CLdPc = 3, CLdAc = 4;
  localparam int unsigned CAdd = 5, CSub = 6, CInc = 7, CAcImm = 8, CAcMem = 9;
  localparam int unsigned CDramWr = 10, CDramRd = 11, CIramRd = 12, CHalt = 13, CZUpd = 14;

  state_e          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d, ar_q, ar_d;
  logic [DW-1:0]   ir_q, ir_d, ac_q, ac_d;
  logic            z_q, z_d;
  logic [14:0]     ctrl;
  logic            restart;
  logic [3:0]      op;
  logic [AW-1:0]   ir_addr;
  logic [DW-1:0]   imm;

  logic [DW-1:0]   iram_mem [2**AW];
  logic [DW-1:0]   dram_mem [2**AW];
  logic [DW-1:0]   iram_rdata, dram_rdata;

  assign op      = ir_q[15:12];
  assign ir_addr = ir_q[AW-1:0];
  assign imm     = {{(DW-12){1'b0}}, ir_q[11:0]};
  assign restart = start_2 | ~start;

  // Control word and next state are a pure function of state and IR.
  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = StFetch;
      StFetch: begin
        ctrl[CLdAr]   = 1'b1;
        ctrl[CIramRd] = 1'b1;
        state_d       = StFetchW;
      end
      StFetchW: begin
        ctrl[CLdIr]  = 1'b1;
        ctrl[CIncPc] = 1'b1;
        state_d      = StDecode;
      end
      StDecode: begin
        case (op)
          OpLoad, OpAdd, OpSub: begin
            ctrl[CLdAr] = 1'b1;
            state_d     = StMemRd;
          end
          OpStore: state_d = StStore;
          OpHalt:  state_d = StHalt;
          default: state_d = StExec;
        endcase
      end
      StMemRd: begin
        ctrl[CDramRd] = 1'b1;
        state_d       = StMemW;
      end
      StMemW: state_d = StExec;
      StExec: begin
        case (op)
          OpLdi:  {ctrl[CLdAc], ctrl[CAcImm], ctrl[CZUpd]} = 3'b111;
          OpLoad: {ctrl[CLdAc], ctrl[CAcMem], ctrl[CZUpd]} = 3'b111;
          OpAdd:  {ctrl[CLdAc], ctrl[CAdd], ctrl[CZUpd]}   = 3'b111;
          OpSub:  {ctrl[CLdAc], ctrl[CSub], ctrl[CZUpd]}   = 3'b111;
          OpInc:  {ctrl[CLdAc], ctrl[CInc], ctrl[CZUpd]}   = 3'b111;
          OpJmp:  ctrl[CLdPc] = 1'b1;
          OpJz:   ctrl[CLdPc] = z_q;
          default: ;
        endcase
        state_d = StFetch;
      end
      StStore: begin
        ctrl[CLdAr]   = 1'b1;
        ctrl[CDramWr] = 1'b1;
        state_d       = StFetch;
      end
      StHalt: ctrl[CHalt] = 1'b1;
      default: state_d = StIdle;
    endcase
    // Load mode or a dropped run enable always parks the core in IDLE.
    if (restart) state_d = StIdle;
  end

  always_comb begin
    alu_in_1 = ac_q;
    alu_in_2 = '0;
    if (op == OpAdd || op == OpSub) alu_in_2 = dram_rdata;
    else if (op == OpInc)           alu_in_2 = DW'(1);
    case (op)
      OpAdd, OpInc: alu_out = alu_in_1 + alu_in_2;
      OpSub:        alu_out = alu_in_1 - alu_in_2;
      default:      alu_out = alu_in_1;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    ar_d = ar_q;
    ir_d = ir_q;
    ac_d = ac_q;
    z_d  = z_q;
    if (ctrl[CLdAr]) ar_d = (state_q == StFetch) ? pc_q : ir_addr;
    if (ctrl[CLdIr]) ir_d = iram_rdata;
    if (ctrl[CIncPc])     pc_d = pc_q + AW'(1);
    else if (ctrl[CLdPc]) pc_d = ir_addr;
    if (restart) pc_d = AW'(PC_INIT);
    if (ctrl[CLdAc]) begin
      if (ctrl[CAcImm])      ac_d = imm;
      else if (ctrl[CAcMem]) ac_d = dram_rdata;
      else                   ac_d = alu_out;
    end
    if (ctrl[CZUpd]) z_d = (ac_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= AW'(PC_INIT);
      ar_q    <= '0;
      ir_q    <= '0;
      ac_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ar_q    <= ar_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
      z_q     <= z_d;
    end
  end

  // Memories are never cleared; reads are registered (one-cycle latency).
  always_ff @(posedge clock) begin
    if (!reset && start_2 && iram_write_ext && state_q == StIdle) begin
      iram_mem[addr_ext] <= Data_in_ins;
    end
    if (ctrl[CIramRd]) iram_rdata <= iram_mem[pc_q];
  end

  always_ff @(posedge clock) begin
    if (!reset && ctrl[CDramWr]) dram_mem[ir_addr] <= ac_q;
    if (ctrl[CDramRd]) dram_rdata <= dram_mem[ar_q];
  end

  assign iram_in     = iram_rdata;
  assign dram_out    = dram_rdata;
  assign dram_in     = ac_q;
  assign pc_out      = {{(DW-AW){1'b0}}, pc_q};
  assign ar_out      = {{(DW-AW){1'b0}}, ar_q};
  assign data_in_pc  = ctrl[CIncPc] ? {{(DW-AW){1'b0}}, pc_q + AW'(1)} :
                       ctrl[CLdPc]  ? {{(DW-AW){1'b0}}, ir_addr} : '0;
  assign control_out = {5'b0, ctrl};
  assign state       = state_q;
  assign read_en     = {ctrl[CIramRd], ctrl[CDramRd]};
  assign write_en    = ctrl[CDramWr];

endmodule

// File: tb/tb_top_control_core.sv
// Program-level bench for top_control_core: table of small programs with expected final
// PC/AC/cycle count and DRAM write traffic, plus hand sequences for load/run control.
module tb_top_control_core;

  logic        clock = 1'b0;
  logic        reset, start, start_2, iram_write_ext;
  logic [8:0]  addr_ext;
  logic [15:0] Data_in_ins;
  logic [15:0] iram_in, dram_in, dram_out, pc_out, ar_out, data_in_pc;
  logic [15:0] alu_in_1, alu_in_2, alu_out;
  logic [19:0] control_out;
  logic [5:0]  state;
  logic [1:0]  read_en;
  logic        write_en;

  top_control_core dut (
    .clock(clock), .reset(reset), .start(start), .start_2(start_2),
    .iram_write_ext(iram_write_ext), .addr_ext(addr_ext), .Data_in_ins(Data_in_ins),
    .iram_in(iram_in), .dram_in(dram_in), .dram_out(dram_out), .pc_out(pc_out),
    .ar_out(ar_out), .data_in_pc(data_in_pc), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_out(alu_out), .control_out(control_out), .state(state), .read_en(read_en),
    .write_en(write_en)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [8:0] a; logic [15:0] d; } wr_t;
  typedef struct packed { logic [15:0] pc; logic [15:0] ac; logic [15:0] cyc; } res_t;
  wr_t  wr_q[$];
  res_t res_q[$];

  // Every DRAM write must match the next expected one; the STORE word is still in iram_in.
  always @(negedge clock) begin
    if (write_en) begin
      if (wr_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected none", iram_in[8:0], dram_in);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check("wr_addr", {23'b0, iram_in[8:0]}, {23'b0, w.a});
        check("wr_data", {16'b0, dram_in}, {16'b0, w.d});
      end
    end
  end

  typedef struct packed {
    logic [4:0]        n;
    logic [15:0][8:0]  addr;
    logic [15:0][15:0] data;
    logic [2:0]        nwr;
    logic [3:0][8:0]   waddr;
    logic [3:0][15:0]  wdata;
    logic [15:0]       exp_pc;
    logic [15:0]       exp_ac;
    logic [15:0]       exp_cyc;
  } case_t;

  localparam int NCase = 6;
  case_t tbl [NCase];
  string case_name [NCase] = '{"run", "readback", "branch", "alu_z", "pc_wrap", "latency"};

  task automatic put(input int c, input logic [8:0] a, input logic [15:0] d);
    tbl[c].addr[tbl[c].n] = a;
    tbl[c].data[tbl[c].n] = d;
    tbl[c].n = tbl[c].n + 5'd1;
  endtask

  task automatic wr(input int c, input logic [8:0] a, input logic [15:0] d);
    tbl[c].waddr[tbl[c].nwr] = a;
    tbl[c].wdata[tbl[c].nwr] = d;
    tbl[c].nwr = tbl[c].nwr + 3'd1;
  endtask

  task automatic expect_res(input int c, input logic [15:0] pc, input logic [15:0] ac,
                            input logic [15:0] cyc);
    tbl[c].exp_pc  = pc;
    tbl[c].exp_ac  = ac;
    tbl[c].exp_cyc = cyc;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; start = 1'b0; start_2 = 1'b0; iram_write_ext = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [8:0] a, input logic [15:0] d, input int hold);
    start_2 = 1'b1; addr_ext = a; Data_in_ins = d; iram_write_ext = 1'b1;
    repeat (hold) @(negedge clock);
    iram_write_ext = 1'b0;
  endtask

  // Pushes the expected outcome, runs until HALT (bounded) and compares the popped record.
  task automatic run_and_check(input string name, input logic [15:0] pc, input logic [15:0] ac,
                               input logic [15:0] cyc);
    int   n;
    res_t r;
    res_q.push_back({pc, ac, cyc});
    start_2 = 1'b0;
    start   = 1'b1;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        check({name, ":fetch_state"}, {26'b0, state}, 32'd1);
        check({name, ":fetch_rd"}, {30'b0, read_en}, 32'd2);
      end
      if (state == 6'd63) break;
    end
    r = res_q.pop_front();
    check({name, ":halt_state"}, {26'b0, state}, 32'd63);
    check({name, ":pc"}, {16'b0, pc_out}, {16'b0, r.pc});
    check({name, ":ac"}, {16'b0, dram_in}, {16'b0, r.ac});
    check({name, ":cycles"}, n, {16'b0, r.cyc});
    repeat (2) @(negedge clock);
    check({name, ":halt_hold"}, {26'b0, state}, 32'd63);
    check({name, ":writes_left"}, wr_q.size(), 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  saw_halt;
    reset = 1'b1; start = 1'b0; start_2 = 1'b0; iram_write_ext = 1'b0;
    addr_ext = '0; Data_in_ins = '0;

    for (int c = 0; c < NCase; c++) tbl[c] = '0;
    put(0, 9'd1, 16'h1005); put(0, 9'd2, 16'h300A); put(0, 9'd3, 16'h400A);
    put(0, 9'd4, 16'h300B); put(0, 9'd5, 16'hF000);
    wr(0, 9'd10, 16'h0005); wr(0, 9'd11, 16'h000A);
    expect_res(0, 16'd6, 16'h000A, 16'd22);
    // Relies on DRAM[10]=5, DRAM[11]=10 surviving reset.
    put(1, 9'd1, 16'h200B); put(1, 9'd2, 16'h500A); put(1, 9'd3, 16'hF000);
    expect_res(1, 16'd4, 16'h0005, 16'd16);
    put(2, 9'd1, 16'h1000); put(2, 9'd2, 16'h7005); put(2, 9'd3, 16'h1007);
    put(2, 9'd4, 16'hF000); put(2, 9'd5, 16'h1009); put(2, 9'd6, 16'h7001);
    put(2, 9'd7, 16'h9123); put(2, 9'd8, 16'hF000);
    expect_res(2, 16'd9, 16'h0009, 16'd24);
    // 0 - 0FFF = F001; 0FFF + F001 wraps to 0 so JZ is taken.
    put(3, 9'd1, 16'h1FFF); put(3, 9'd2, 16'h3014); put(3, 9'd3, 16'h1000);
    put(3, 9'd4, 16'h5014); put(3, 9'd5, 16'h3015); put(3, 9'd6, 16'h1FFF);
    put(3, 9'd7, 16'h4015); put(3, 9'd8, 16'h700B); put(3, 9'd9, 16'h1001);
    put(3, 9'd10, 16'hF000); put(3, 9'd11, 16'h3016); put(3, 9'd12, 16'h8000);
    put(3, 9'd13, 16'hF000);
    wr(3, 9'd20, 16'h0FFF); wr(3, 9'd21, 16'hF001); wr(3, 9'd22, 16'h0000);
    expect_res(3, 16'd14, 16'h0001, 16'd48);
    put(4, 9'd1, 16'h61FF); put(4, 9'd511, 16'h8000); put(4, 9'd0, 16'hF000);
    expect_res(4, 16'd1, 16'h0001, 16'd12);
    put(5, 9'd1, 16'h0000); put(5, 9'd2, 16'h200A); put(5, 9'd3, 16'hF000);
    expect_res(5, 16'd4, 16'h0005, 16'd14);

    // Reset state.
    do_reset();
    check("rst_state", {26'b0, state}, 32'd0);
    check("rst_pc", {16'b0, pc_out}, 32'd1);
    check("rst_ctrl", {12'b0, control_out}, 32'd0);
    check("rst_we", {31'b0, write_en}, 32'd0);
    check("rst_re", {30'b0, read_en}, 32'd0);
    check("rst_ar", {16'b0, ar_out}, 32'd0);
    check("rst_ac", {16'b0, dram_in}, 32'd0);

    // Load mode with long strobes, then run the two-word program.
    load_word(9'd1, 16'h1005, 4);
    check("load_state1", {26'b0, state}, 32'd0);
    load_word(9'd2, 16'hF000, 4);
    check("load_state2", {26'b0, state}, 32'd0);
    check("load_pc", {16'b0, pc_out}, 32'd1);
    run_and_check("load_run", 16'd3, 16'h0005, 16'd8);

    // start_2 overrides start: no fetch.
    do_reset();
    start = 1'b1; start_2 = 1'b1;
    repeat (5) @(negedge clock);
    check("ovr_state", {26'b0, state}, 32'd0);
    check("ovr_pc", {16'b0, pc_out}, 32'd1);
    check("ovr_re", {30'b0, read_en}, 32'd0);

    // Endless INC/JMP loop: drop start mid-run, and loader strobes while running are ignored.
    do_reset();
    load_word(9'd1, 16'h8000, 1);
    load_word(9'd2, 16'h6001, 1);
    start_2 = 1'b0; start = 1'b1;
    repeat (13) @(negedge clock);
    addr_ext = 9'd2; Data_in_ins = 16'hF000; iram_write_ext = 1'b1;
    repeat (3) @(negedge clock);
    check("loop_running", {31'b0, state == 6'd0}, 32'd0);
    start = 1'b0;
    @(negedge clock);
    check("drop_state", {26'b0, state}, 32'd0);
    check("drop_pc", {16'b0, pc_out}, 32'd1);
    iram_write_ext = 1'b0;
    start = 1'b1;
    saw_halt = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (state == 6'd63) saw_halt = 1'b1;
    end
    check("ignored_wr", {31'b0, saw_halt}, 32'd0);

    for (int c = 0; c < NCase; c++) begin
      do_reset();
      for (int i = 0; i < int'(tbl[c].n); i++) load_word(tbl[c].addr[i], tbl[c].data[i], 1);
      for (int i = 0; i < int'(tbl[c].nwr); i++) wr_q.push_back({tbl[c].waddr[i], tbl[c].wdata[i]});
      run_and_check(case_name[c], tbl[c].exp_pc, tbl[c].exp_ac, tbl[c].exp_cyc);
      wr_q.delete();
    end

    cyc = n_vec;
    $display("== %0d vectors applied, %0d miscompares ==", cyc, n_bad);
    $finish;
  end

endmodule
